// File: rtl/alu_pkg.sv
// Shared ALU comparator definitions: opcode encodings, sequencer state type
// and the legal-opcode test used by alu_cmp_sequencer.
package alu_pkg;

    localparam int CMP_OP_W = 5;

    localparam logic [CMP_OP_W-1:0] OP_BEQ  = 5'd0;
    localparam logic [CMP_OP_W-1:0] OP_BNE  = 5'd1;
    localparam logic [CMP_OP_W-1:0] OP_BLT  = 5'd2;
    localparam logic [CMP_OP_W-1:0] OP_BGE  = 5'd3;
    localparam logic [CMP_OP_W-1:0] OP_BLTU = 5'd4;
    localparam logic [CMP_OP_W-1:0] OP_BGEU = 5'd5;
    localparam logic [CMP_OP_W-1:0] OP_SLT  = 5'd9;
    localparam logic [CMP_OP_W-1:0] OP_SLTU = 5'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_RESP
    } seq_state_e;

    function automatic logic is_legal_cmp_op(input logic [CMP_OP_W-1:0] op);
        case (op)
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_SLT, OP_SLTU:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cmp_rr_arbiter.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie
// and moves to the other requester whenever a grant is taken.
module cmp_rr_arbiter (
    input  logic       soc_clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && (grant != 2'b00)) begin
            ptr_d = grant[0];
        end
    end

    always_ff @(posedge soc_clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_cmp_sequencer.sv
// Shares one registered comparator between the branch path (req 0) and the
// SLT/SLTU path (req 1). Optional illegal-op bypass: ALU_CMP_SEQ_ILLEGAL_OP_EN.
//   state      | meaning
//   ST_IDLE    | waiting for a request, arbiter active
//   ST_ISSUE   | cmp_dat_ready pulsed, comparator samples at closing edge
//   ST_CAPTURE | comparator result latched into response registers
//   ST_RESP    | response held until the granted requester takes it
module alu_cmp_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5
) (
    input  logic                soc_clk,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*OP_W-1:0]   req_op,
    input  logic [2*DATA_W-1:0] req_dat1,
    input  logic [2*DATA_W-1:0] req_dat2,
    output logic [1:0]          resp_valid,
    input  logic [1:0]          resp_ready,
    output logic                resp_con_met,
    output logic [DATA_W-1:0]   resp_data,
    output logic                resp_err,
    output logic                cmp_dat_ready,
    output logic [OP_W-1:0]     cmp_instr,
    output logic [DATA_W-1:0]   cmp_dat1,
    output logic [DATA_W-1:0]   cmp_dat2,
    input  logic                cmp_con_met,
    input  logic [DATA_W-1:0]   cmp_out,
    output logic                busy
);

    seq_state_e        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic [OP_W-1:0]   cmp_instr_q, cmp_instr_d;
    logic [DATA_W-1:0] cmp_dat1_q, cmp_dat1_d;
    logic [DATA_W-1:0] cmp_dat2_q, cmp_dat2_d;
    logic              cmp_dat_ready_q, cmp_dat_ready_d;
    logic [1:0]        resp_valid_q, resp_valid_d;
    logic              resp_con_met_q, resp_con_met_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
`ifdef ALU_CMP_SEQ_ILLEGAL_OP_EN
    logic              resp_err_q, resp_err_d;
`endif

    logic [1:0]        arb_req;
    logic [1:0]        arb_grant;
    logic              accept;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_dat1;
    logic [DATA_W-1:0] sel_dat2;

    assign arb_req = (state_q == ST_IDLE) ? req_valid : 2'b00;

    cmp_rr_arbiter u_arb (
        .soc_clk (soc_clk),
        .reset   (reset),
        .req     (arb_req),
        .advance (accept),
        .grant   (arb_grant)
    );

    // Ready is held low while reset is asserted even though state already reads IDLE.
    assign req_ready = reset ? 2'b00 : arb_grant;
    assign accept    = (req_ready != 2'b00);

    assign sel_op   = req_ready[1] ? req_op[2*OP_W-1:OP_W]       : req_op[OP_W-1:0];
    assign sel_dat1 = req_ready[1] ? req_dat1[2*DATA_W-1:DATA_W] : req_dat1[DATA_W-1:0];
    assign sel_dat2 = req_ready[1] ? req_dat2[2*DATA_W-1:DATA_W] : req_dat2[DATA_W-1:0];

    always_comb begin
        state_d         = state_q;
        gnt_d           = gnt_q;
        cmp_instr_d     = cmp_instr_q;
        cmp_dat1_d      = cmp_dat1_q;
        cmp_dat2_d      = cmp_dat2_q;
        cmp_dat_ready_d = 1'b0;
        resp_valid_d    = resp_valid_q;
        resp_con_met_d  = resp_con_met_q;
        resp_data_d     = resp_data_q;
`ifdef ALU_CMP_SEQ_ILLEGAL_OP_EN
        resp_err_d      = resp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    gnt_d = req_ready[1];
`ifdef ALU_CMP_SEQ_ILLEGAL_OP_EN
                    if (!is_legal_cmp_op(sel_op)) begin
                        state_d        = ST_RESP;
                        resp_valid_d   = req_ready;
                        resp_con_met_d = 1'b0;
                        resp_data_d    = '0;
                        resp_err_d     = 1'b1;
                    end else
`endif
                    begin
                        state_d         = ST_ISSUE;
                        cmp_instr_d     = sel_op;
                        cmp_dat1_d      = sel_dat1;
                        cmp_dat2_d      = sel_dat2;
                        cmp_dat_ready_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d        = ST_RESP;
                resp_con_met_d = cmp_con_met;
                resp_data_d    = cmp_out;
                resp_valid_d   = gnt_q ? 2'b10 : 2'b01;
`ifdef ALU_CMP_SEQ_ILLEGAL_OP_EN
                resp_err_d     = 1'b0;
`endif
            end
            ST_RESP: begin
                if (resp_ready[gnt_q]) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 2'b00;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge soc_clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            gnt_q           <= 1'b0;
            cmp_instr_q     <= '0;
            cmp_dat1_q      <= '0;
            cmp_dat2_q      <= '0;
            cmp_dat_ready_q <= 1'b0;
            resp_valid_q    <= 2'b00;
            resp_con_met_q  <= 1'b0;
            resp_data_q     <= '0;
`ifdef ALU_CMP_SEQ_ILLEGAL_OP_EN
            resp_err_q      <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            gnt_q           <= gnt_d;
            cmp_instr_q     <= cmp_instr_d;
            cmp_dat1_q      <= cmp_dat1_d;
            cmp_dat2_q      <= cmp_dat2_d;
            cmp_dat_ready_q <= cmp_dat_ready_d;
            resp_valid_q    <= resp_valid_d;
            resp_con_met_q  <= resp_con_met_d;
            resp_data_q     <= resp_data_d;
`ifdef ALU_CMP_SEQ_ILLEGAL_OP_EN
            resp_err_q      <= resp_err_d;
`endif
        end
    end

    assign cmp_instr     = cmp_instr_q;
    assign cmp_dat1      = cmp_dat1_q;
    assign cmp_dat2      = cmp_dat2_q;
    assign cmp_dat_ready = cmp_dat_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_con_met  = resp_con_met_q;
    assign resp_data     = resp_data_q;
    assign busy          = (state_q != ST_IDLE);
`ifdef ALU_CMP_SEQ_ILLEGAL_OP_EN
    assign resp_err      = resp_err_q;
`else
    assign resp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmp_sequencer.sv
// Directed bench for alu_cmp_sequencer with a small registered comparator
// standing in for the real one; honours ALU_CMP_SEQ_ILLEGAL_OP_EN.
module tb_alu_cmp_sequencer;

    localparam int DATA_W = 32;
    localparam int OP_W   = 5;

    logic                soc_clk = 1'b0;
    logic                reset;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*OP_W-1:0]   req_op;
    logic [2*DATA_W-1:0] req_dat1;
    logic [2*DATA_W-1:0] req_dat2;
    logic [1:0]          resp_valid;
    logic [1:0]          resp_ready;
    logic                resp_con_met;
    logic [DATA_W-1:0]   resp_data;
    logic                resp_err;
    logic                cmp_dat_ready;
    logic [OP_W-1:0]     cmp_instr;
    logic [DATA_W-1:0]   cmp_dat1;
    logic [DATA_W-1:0]   cmp_dat2;
    logic                cmp_con_met;
    logic [DATA_W-1:0]   cmp_out;
    logic                busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 soc_clk = ~soc_clk;

    alu_cmp_sequencer #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .soc_clk       (soc_clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_dat1      (req_dat1),
        .req_dat2      (req_dat2),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_con_met  (resp_con_met),
        .resp_data     (resp_data),
        .resp_err      (resp_err),
        .cmp_dat_ready (cmp_dat_ready),
        .cmp_instr     (cmp_instr),
        .cmp_dat1      (cmp_dat1),
        .cmp_dat2      (cmp_dat2),
        .cmp_con_met   (cmp_con_met),
        .cmp_out       (cmp_out),
        .busy          (busy)
    );

    // Stand-in comparator: {con_met, out}, sampled when dat_ready is high.
    function automatic logic [32:0] cmp_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic c;
        c = 1'b0;
        case (op)
            5'd0:  c = (a == b);
            5'd1:  c = (a != b);
            5'd2:  c = ($signed(a) <  $signed(b));
            5'd3:  c = ($signed(a) >= $signed(b));
            5'd4:  c = (a <  b);
            5'd5:  c = (a >= b);
            5'd9:  return {($signed(a) < $signed(b)), 31'd0, ($signed(a) < $signed(b))};
            5'd10: return {(a < b), 31'd0, (a < b)};
            default: c = 1'b0;
        endcase
        return {c, 32'd0};
    endfunction

    always @(posedge soc_clk or posedge reset) begin
        if (reset) begin
            cmp_con_met <= 1'b0;
            cmp_out     <= '0;
        end else if (cmp_dat_ready) begin
            {cmp_con_met, cmp_out} <= cmp_model(cmp_instr, cmp_dat1, cmp_dat2);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of the cycle after accept.
    task automatic send(input int r, input logic [4:0] op, input logic [31:0] d1,
                        input logic [31:0] d2, input bit to_cmp);
        req_op[r*OP_W +: OP_W]       = op;
        req_dat1[r*DATA_W +: DATA_W] = d1;
        req_dat2[r*DATA_W +: DATA_W] = d2;
        req_valid = (r == 1) ? 2'b10 : 2'b01;
        #1;
        check("req_ready_idle", {62'd0, req_ready}, (r == 1) ? 64'd2 : 64'd1);
        @(posedge soc_clk);
        @(negedge soc_clk);
        req_valid = 2'b00;
        check("busy_after_accept", {63'd0, busy}, 64'd1);
        check("req_ready_busy", {62'd0, req_ready}, 64'd0);
        if (to_cmp) begin
            check("cmp_instr", {59'd0, cmp_instr}, {59'd0, op});
            check("cmp_dat", {cmp_dat1, cmp_dat2}, {d1, d2});
        end
    endtask

    task automatic await_resp(output int lat, output int pulses, output int pk);
        lat = 99;
        pulses = 0;
        pk = 0;
        for (int k = 1; k <= 10; k++) begin
            if (cmp_dat_ready) begin
                pulses++;
                if (pk == 0) pk = k;
            end
            if (resp_valid != 2'b00) begin
                lat = k;
                break;
            end
            @(negedge soc_clk);
        end
    endtask

    task automatic consume(input int r);
        resp_ready = (r == 1) ? 2'b10 : 2'b01;
        @(posedge soc_clk);
        @(negedge soc_clk);
        resp_ready = 2'b00;
        check("resp_cleared", {61'd0, resp_valid, busy}, 64'd0);
    endtask

    task automatic expect_resp(input string tag, input int lat, input int pulses, input int pk,
                               input int exp_lat, input int exp_pulses, input logic [1:0] exp_v,
                               input logic exp_con, input logic [31:0] exp_data, input logic exp_err);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_pulses"}, {32'd0, 32'(pulses)}, {32'd0, 32'(exp_pulses)});
        if (exp_pulses == 1) check({tag, "_pulse_at"}, 64'(pk), 64'd1);
        check({tag, "_resp"}, {28'd0, resp_valid, resp_con_met, resp_err, resp_data},
              {28'd0, exp_v, exp_con, exp_err, exp_data});
    endtask

    int lat, pulses, pk;
    int n_acc;
    logic [1:0] gnt [4];
    int acc_c [4];

    initial begin
        reset      = 1'b1;
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        req_op     = '0;
        req_dat1   = '0;
        req_dat2   = '0;
        repeat (2) @(negedge soc_clk);
        req_valid = 2'b11;
        #1;
        check("rst_req_ready", {62'd0, req_ready}, 64'd0);
        check("rst_ctrl", {58'd0, resp_valid, busy, cmp_dat_ready, resp_con_met, resp_err}, 64'd0);
        check("rst_regs", {27'd0, cmp_instr, resp_data}, 64'd0);
        check("rst_cmp_dat", {cmp_dat1, cmp_dat2}, 64'd0);
        req_valid = 2'b00;
        @(negedge soc_clk);
        reset = 1'b0;
        @(negedge soc_clk);

        // Req0 BLT -1 < 1
        send(0, 5'd2, 32'hFFFF_FFFF, 32'd1, 1'b1);
        await_resp(lat, pulses, pk);
        expect_resp("blt", lat, pulses, pk, 3, 1, 2'b01, 1'b1, 32'd0, 1'b0);
        consume(0);

        // Req1 SLTU then SLT on the same operands
        send(1, 5'd10, 32'hFFFF_FFFF, 32'd1, 1'b1);
        await_resp(lat, pulses, pk);
        expect_resp("sltu", lat, pulses, pk, 3, 1, 2'b10, 1'b0, 32'd0, 1'b0);
        consume(1);
        send(1, 5'd9, 32'hFFFF_FFFF, 32'd1, 1'b1);
        await_resp(lat, pulses, pk);
        expect_resp("slt", lat, pulses, pk, 3, 1, 2'b10, 1'b1, 32'd1, 1'b0);
        consume(1);

        // Both requesters valid continuously, responses always taken
        req_op     = {5'd9, 5'd0};
        req_dat1   = {32'd2, 32'd7};
        req_dat2   = {32'd3, 32'd7};
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        n_acc = 0;
        for (int c = 0; c < 40 && n_acc < 4; c++) begin
            #1;
            if (req_ready != 2'b00) begin
                gnt[n_acc]   = req_ready;
                acc_c[n_acc] = c;
                n_acc++;
            end
            @(posedge soc_clk);
            @(negedge soc_clk);
        end
        req_valid = 2'b00;
        check("rr_accepts", 64'(n_acc), 64'd4);
        check("rr_order", {56'd0, gnt[0], gnt[1], gnt[2], gnt[3]}, {56'd0, 8'b01_10_01_10});
        check("rr_spacing", {32'(acc_c[1] - acc_c[0]), 32'(acc_c[3] - acc_c[2])}, {32'd4, 32'd4});
        for (int k = 0; k < 10 && busy; k++) @(negedge soc_clk);
        resp_ready = 2'b00;
        check("rr_drained", {63'd0, busy}, 64'd0);

        // Back-pressure: response held for 5 cycles, other requester waiting
        send(1, 5'd9, 32'hFFFF_FFFB, 32'd3, 1'b1);
        await_resp(lat, pulses, pk);
        expect_resp("hold_slt", lat, pulses, pk, 3, 1, 2'b10, 1'b1, 32'd1, 1'b0);
        req_valid  = 2'b01;
        resp_ready = 2'b01;
        for (int i = 0; i < 5; i++) begin
            @(negedge soc_clk);
            check("hold_stable", {26'd0, resp_valid, resp_con_met, resp_data, req_ready, cmp_dat_ready},
                  {26'd0, 2'b10, 1'b1, 32'd1, 2'b00, 1'b0});
        end
        req_valid = 2'b00;
        consume(1);

        // Reset during CAPTURE, then pointer must be back to requester 0
        send(0, 5'd3, 32'd5, 32'hFFFF_FFFD, 1'b1);
        @(negedge soc_clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_ctrl", {57'd0, req_ready, resp_valid, busy, cmp_dat_ready, resp_con_met},
              64'd0);
        check("midrst_regs", {27'd0, cmp_instr, resp_data}, 64'd0);
        @(negedge soc_clk);
        reset = 1'b0;
        @(negedge soc_clk);
        req_op    = {5'd9, 5'd0};
        req_dat1  = {32'd1, 32'd4};
        req_dat2  = {32'd1, 32'd4};
        req_valid = 2'b11;
        #1;
        check("ptr_after_rst", {62'd0, req_ready}, 64'd1);
        @(posedge soc_clk);
        @(negedge soc_clk);
        req_valid = 2'b00;
        await_resp(lat, pulses, pk);
        expect_resp("post_rst_beq", lat, pulses, pk, 3, 1, 2'b01, 1'b1, 32'd0, 1'b0);
        consume(0);

        // Opcode 7 is not a comparator op
`ifdef ALU_CMP_SEQ_ILLEGAL_OP_EN
        send(1, 5'd7, 32'd1, 32'd2, 1'b0);
        await_resp(lat, pulses, pk);
        expect_resp("illegal", lat, pulses, pk, 1, 0, 2'b10, 1'b0, 32'd0, 1'b1);
`else
        send(1, 5'd7, 32'd1, 32'd2, 1'b1);
        await_resp(lat, pulses, pk);
        expect_resp("illegal", lat, pulses, pk, 3, 1, 2'b10, 1'b0, 32'd0, 1'b0);
`endif
        consume(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_cmp_sequencer.md
# alu_cmp_sequencer

Sequences and shares the ALU comparator between two requesters: requester 0 is the branch-resolution path (ops 0–5) and requester 1 is the integer SLT/SLTU path (ops 9, 10). Each requester uses a valid/ready request channel. The block picks one requester by round-robin, drives the comparator's registered one-cycle interface, captures the result, and returns it on a per-requester valid/ready response channel. It sits in the ALU top, between the decode/issue logic and the comparator instance.

## Interface
- DATA_W, 32, operand/result width
- OP_W, 5, opcode width (comparator encoding: 0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU, 9 SLT, 10 SLTU)
- soc_clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  2  request valid, bit i = requester i
- req_ready  out  2  request accepted when valid&ready
- req_op  in  2*OP_W  opcode; slice i belongs to requester i
- req_dat1  in  2*DATA_W  operand 1 per requester
- req_dat2  in  2*DATA_W  operand 2 per requester
- resp_valid  out  2  response valid; at most one bit set
- resp_ready  in  2  response consumed when valid&ready
- resp_con_met  out  1  condition flag
- resp_data  out  DATA_W  SLT/SLTU result; 0 for branches
- resp_err  out  1  illegal opcode (see Configuration)
- cmp_dat_ready  out  1  to comparator dat_ready
- cmp_instr  out  OP_W  to comparator opcode input
- cmp_dat1, cmp_dat2  out  DATA_W  to comparator operands
- cmp_con_met  in  1  from comparator
- cmp_out  in  DATA_W  from comparator
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- **IDLE**
  - req_ready[g] = req_valid[g] for the granted requester g; the other bit is 0.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester named by the priority pointer is granted.
  - On handshake: latch op and operands into cmp_instr/cmp_dat1/cmp_dat2, record g, go to ISSUE. The pointer is set to the other requester.
- **ISSUE**
  - cmp_dat_ready=1 for exactly this cycle. The comparator samples at the closing edge.
  - Go to CAPTURE.
- **CAPTURE**
  - cmp_dat_ready=0.
  - Latch cmp_con_met → resp_con_met and cmp_out → resp_data. resp_err=0.
  - Go to RESP.
- **RESP**
  - resp_valid[g]=1, with payload held stable until resp_ready[g].
  - On handshake: go to IDLE and clear resp_valid.
  - resp_ready of the non-granted requester is ignored.
- Outside ISSUE, cmp_dat_ready is 0. cmp_instr/cmp_dat1/cmp_dat2 hold their last value.
- The pointer advances only on a grant. Idle cycles leave it unchanged.

## Timing
- Reset values:
  - state=IDLE, pointer=0.
  - req_ready, resp_valid, busy, cmp_dat_ready, resp_con_met, resp_err = 0.
  - resp_data, cmp_dat1, cmp_dat2, cmp_instr = 0.
- Latency, with request accepted at edge t:
  - ISSUE occupies cycle t+1.
  - CAPTURE occupies t+2.
  - resp_valid is high from t+3.
- Throughput: with resp_ready held high, a new accept is possible at t+4, so one op per 4 cycles.
- Only one op is in flight. req_ready is 0 in all states except IDLE.
- Reset asserted mid-operation forces IDLE immediately (asynchronously):
  - any in-flight or unconsumed response is dropped;
  - cmp_dat_ready drops the same cycle;
  - the requester must re-issue.
- req_valid deasserted without a handshake is legal; nothing is latched.
- Both requests valid for consecutive operations: grants alternate 0,1,0,1…

## Configuration
- Macro: ALU_CMP_SEQ_ILLEGAL_OP_EN.
- **Defined:** an accepted op outside {0–5, 9, 10} never reaches the comparator.
  - IDLE → RESP directly; ISSUE and CAPTURE are skipped and cmp_dat_ready stays 0.
  - Response: resp_err=1, resp_con_met=0, resp_data=0, resp_valid high at t+1.
  - The pointer updates as for a legal op.
- **Undefined:** all ops follow the normal path and the comparator returns 0/0. resp_err is tied 0. The port remains.

## Structure
- Shared package alu_pkg:
  - opcode constants (OP_BEQ … OP_BGEU, OP_SLT=9, OP_SLTU=10);
  - FSM state enum;
  - is_legal_cmp_op() function.
- Sub-module cmp_rr_arbiter: 2-way round-robin arbiter.
  - Inputs: req[1:0], advance strobe.
  - Outputs: one-hot grant.
  - Holds the priority pointer; reset pointer=0.
- The comparator is instantiated by the ALU top, not inside this block.

## Test plan
- Req0 BLT with dat1=0xFFFFFFFF, dat2=1 accepted at t → cmp_dat_ready=1 only in t+1; resp_valid=2'b01 at t+3 with con_met=1, data=0.
- Req1 SLTU with dat1=0xFFFFFFFF, dat2=1 → resp_valid=2'b10, con_met=0, data=0. Then SLT with the same operands → data=1, con_met=1.
- Both valid continuously for 4 ops, resp_ready=2'b11 → grant order 0,1,0,1; accepts 4 cycles apart.
- resp_ready held 0 for 5 cycles in RESP → resp_valid and payload stable; req_ready=0; no cmp_dat_ready pulse.
- Reset asserted during CAPTURE → all outputs 0 the same cycle; the next request is serviced from IDLE with pointer=0.
- With ALU_CMP_SEQ_ILLEGAL_OP_EN, op=7 → resp_err=1, data=0, resp_valid at t+1, no cmp_dat_ready pulse. Without the macro → resp at t+3, err=0, con_met=0.
